minirisc_multicycle_ctrl: RTL

Multi-cycle control FSM for the KGP-miniRISC core. It sequences instruction fetch, decode, execute, data-memory access and writeback. It drives the immediate-extension select feeding the sign/zero-extend datapath, the ALU operand and op selects, the PC/IR/register-file write enables and the instruction/data memory request handshakes. It also counts retired instructions.

---
 rtl/minirisc_ctrl_pkg.sv | 67 ++++++
 rtl/minirisc_ctrl_decode.sv | 83 ++++++++
 rtl/minirisc_multicycle_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/minirisc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// minirisc_ctrl_pkg
// Shared encodings for the KGP-miniRISC multi-cycle controller: FSM state
// encoding, instruction class, opcode map, ALU op codes and the select
// encodings for the immediate extender, writeback mux and PC source mux.
// No ports (package).
// -----------------------------------------------------------------------------
package minirisc_ctrl_pkg;

  // FSM states; S_TRAP is only reachable when ILLEGAL_TRAP_EN is defined
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // Instruction class as seen by the FSM sequencing
  typedef enum logic [3:0] {
    CLS_ALU  = 4'd0,
    CLS_LD   = 4'd1,
    CLS_ST   = 4'd2,
    CLS_BR   = 4'd3,
    CLS_BZ   = 4'd4,
    CLS_BNZ  = 4'd5,
    CLS_BL   = 4'd6,
    CLS_HALT = 4'd7,
    CLS_ILL  = 4'd8
  } op_class_e;

  // Opcode map (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_ANDI  = 6'h02;
  localparam logic [5:0] OP_LD    = 6'h03;
  localparam logic [5:0] OP_ST    = 6'h04;
  localparam logic [5:0] OP_BR    = 6'h05;
  localparam logic [5:0] OP_BZ    = 6'h06;
  localparam logic [5:0] OP_BNZ   = 6'h07;
  localparam logic [5:0] OP_BL    = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h09;

  // ALU operation codes (R-type passes funct straight through)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;

  // Immediate extender select
  localparam logic [1:0] EXT_SEXT16 = 2'b00;
  localparam logic [1:0] EXT_ZEXT16 = 2'b01;
  localparam logic [1:0] EXT_SEXT26 = 2'b10;

  // Writeback source select
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  // PC source select
  localparam logic PC_SRC_INC    = 1'b0;
  localparam logic PC_SRC_OFFSET = 1'b1;

endpackage

// File: rtl/minirisc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// minirisc_ctrl_decode
// Purely combinational opcode/funct decoder for the multi-cycle controller.
// Ports:
//   opcode    in  6  IR[31:26]
//   funct     in  4  IR[3:0], R-type ALU function
//   ext_sel   out 2  immediate extension select
//   alu_src_b out 1  0 = register, 1 = extended immediate
//   alu_op    out 4  ALU operation code
//   wb_sel    out 2  writeback source select
//   op_class  out    instruction class used by the FSM
// -----------------------------------------------------------------------------
module minirisc_ctrl_decode
  import minirisc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [3:0] funct,
  output logic [1:0] ext_sel,
  output logic       alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] wb_sel,
  output op_class_e  op_class
);

  // Map each opcode onto its datapath selects and class. Anything not in
  // the opcode map falls out as CLS_ILL with harmless default selects.
  always_comb begin
    ext_sel   = EXT_SEXT16;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    op_class  = CLS_ILL;
    case (opcode)
      OP_RTYPE: begin
        alu_op   = funct;
        op_class = CLS_ALU;
      end
      OP_ADDI: begin
        alu_src_b = 1'b1;
        op_class  = CLS_ALU;
      end
      OP_ANDI: begin
        ext_sel   = EXT_ZEXT16;
        alu_src_b = 1'b1;
        alu_op    = ALU_AND;
        op_class  = CLS_ALU;
      end
      OP_LD: begin
        alu_src_b = 1'b1;
        wb_sel    = WB_MEM;
        op_class  = CLS_LD;
      end
      OP_ST: begin
        alu_src_b = 1'b1;
        op_class  = CLS_ST;
      end
      OP_BR: begin
        ext_sel  = EXT_SEXT26;
        op_class = CLS_BR;
      end
      OP_BZ: begin
        ext_sel  = EXT_SEXT26;
        op_class = CLS_BZ;
      end
      OP_BNZ: begin
        ext_sel  = EXT_SEXT26;
        op_class = CLS_BNZ;
      end
      OP_BL: begin
        ext_sel  = EXT_SEXT26;
        wb_sel   = WB_LINK;
        op_class = CLS_BL;
      end
      OP_HALT: begin
        op_class = CLS_HALT;
      end
      default: begin
        op_class = CLS_ILL;
      end
    endcase
  end

endmodule

// File: rtl/minirisc_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// minirisc_multicycle_ctrl
// Multi-cycle control FSM for the KGP-miniRISC core: FETCH, DECODE, EXEC,
// MEM, WB, HALT (and TRAP). Control outputs are combinational from state,
// decoded opcode/funct and the memory acks; state and the retired-instruction
// counter are registered. All outputs are forced to 0 while rst is high.
// Optional build macro: ILLEGAL_TRAP_EN -- undefined opcodes trap instead of
// executing as a NOP.
// Ports:
//   clk, rst             clock, async active-high reset
//   opcode, funct        IR fields
//   rs_zero              source register == 0 (EXEC)
//   imem_ack, dmem_ack   memory handshakes
//   imem_req, dmem_req, dmem_we
//   ir_write, pc_write, pc_src, ext_sel, alu_src_b, alu_op
//   reg_write, wb_sel, halted, trap, retire_cnt
// -----------------------------------------------------------------------------
module minirisc_multicycle_ctrl
  import minirisc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [3:0]          funct,
  input  logic                rs_zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic [1:0]          ext_sel,
  output logic                alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                halted,
  output logic                trap,
  output logic [CNT_W-1:0]    retire_cnt
);

  state_e     state;
  state_e     next_state;
  logic       retire;
  logic [1:0] dec_ext_sel;
  logic       dec_alu_src_b;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_wb_sel;
  op_class_e  dec_class;

  minirisc_ctrl_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .ext_sel   (dec_ext_sel),
    .alu_src_b (dec_alu_src_b),
    .alu_op    (dec_alu_op),
    .wb_sel    (dec_wb_sel),
    .op_class  (dec_class)
  );

  // Next-state and control decode. The operand selects are only presented
  // while the datapath is using them (EXEC/MEM); wb_sel only in WB. The rst
  // override at the bottom makes requests drop the moment reset rises,
  // instead of waiting for the state register to settle.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_INC;
    ext_sel    = EXT_SEXT16;
    alu_src_b  = 1'b0;
    alu_op     = '0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    halted     = 1'b0;
    trap       = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_SRC_INC;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_class == CLS_HALT) begin
          next_state = S_HALT;
        end else if (dec_class == CLS_ILL) begin
`ifdef ILLEGAL_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_FETCH;
`endif
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        ext_sel   = dec_ext_sel;
        alu_src_b = dec_alu_src_b;
        alu_op    = ALU_OP_W'(dec_alu_op);
        case (dec_class)
          CLS_ALU: next_state = S_WB;
          CLS_LD,
          CLS_ST:  next_state = S_MEM;
          CLS_BR: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_OFFSET;
            next_state = S_FETCH;
          end
          CLS_BZ: begin
            pc_write   = rs_zero;
            pc_src     = rs_zero;
            next_state = S_FETCH;
          end
          CLS_BNZ: begin
            pc_write   = ~rs_zero;
            pc_src     = ~rs_zero;
            next_state = S_FETCH;
          end
          CLS_BL: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_OFFSET;
            next_state = S_WB;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        ext_sel   = dec_ext_sel;
        alu_src_b = dec_alu_src_b;
        alu_op    = ALU_OP_W'(dec_alu_op);
        dmem_req  = 1'b1;
        dmem_we   = (dec_class == CLS_ST);
        if (dmem_ack) begin
          next_state = (dec_class == CLS_LD) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        wb_sel     = dec_wb_sel;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        halted = 1'b1;
        trap   = 1'b1;
      end
`endif
      default: next_state = S_FETCH;
    endcase
    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      ext_sel   = 2'b00;
      alu_src_b = 1'b0;
      alu_op    = '0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      halted    = 1'b0;
      trap      = 1'b0;
    end
  end

  // An instruction retires on its final cycle, which is exactly the cycle
  // that moves the FSM back into FETCH from somewhere else.
  assign retire = (next_state == S_FETCH) && (state != S_FETCH);

  // State register and wrapping retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      retire_cnt <= '0;
    end else begin
      state <= next_state;
      if (retire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule
